// File: rtl/graycode_pkg.sv
// Shared constants and pure Gray-code helpers for the graycode counter slice.
// The helpers work on zero-extended 32-bit values, so one function serves
// any width from 1 to 32: callers widen the input and keep the low bits.
package graycode_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 32;

  // Binary to reflected Gray code.
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray back to binary. Each bit is the XOR of itself with all higher bits.
  // Zero bits above the caller's width leave the result unchanged.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/graycode_bin2gray.sv
// Combinational binary-to-Gray converter, WIDTH bits in and out.
module graycode_bin2gray
  import graycode_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  logic [MAX_WIDTH-1:0] bin_ext;
  logic [MAX_WIDTH-1:0] gray_ext;

  // Widen, convert through the shared helper, keep the low WIDTH bits.
  always_comb begin
    bin_ext  = '0;
    bin_ext[WIDTH-1:0] = bin;
    gray_ext = bin2gray(bin_ext);
    gray     = gray_ext[WIDTH-1:0];
  end

endmodule

// File: rtl/top_graycode.sv
// Free-running Gray-code counter with binary mirror and a one-cycle rollover
// pulse. resetn is synchronous and active HIGH despite its name.
// out is loaded from the Gray value of the *next* count so it is a pure
// register output, never decoded from bin_out.
module top_graycode
  import graycode_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic [DATA_WIDTH-1:0] out,
  output logic [DATA_WIDTH-1:0] bin_out,
  output logic                  wrap
);

  logic [DATA_WIDTH-1:0] count_q;
  logic [DATA_WIDTH-1:0] count_next;
  logic [DATA_WIDTH-1:0] gray_next;
  logic                  wrap_next;

  // Next count wraps naturally modulo 2^DATA_WIDTH; rollover when it hits 0.
  always_comb begin
    count_next = count_q + 1'b1;
    wrap_next  = (count_next == '0);
  end

  graycode_bin2gray #(
    .WIDTH(DATA_WIDTH)
  ) u_bin2gray (
    .bin  (count_next),
    .gray (gray_next)
  );

  // All state: counter, Gray output register and rollover pulse.
  always_ff @(posedge clk) begin
    if (resetn) begin
      count_q <= '0;
      out     <= '0;
      wrap    <= 1'b0;
    end else begin
      count_q <= count_next;
      out     <= gray_next;
      wrap    <= wrap_next;
    end
  end

  assign bin_out = count_q;

endmodule

// File: tb/tb_top_graycode.sv
// Bench for top_graycode: three instances (widths 1, 4, 8) share clock and
// reset. A behavioural model holds each count as a plain integer.
module tb_top_graycode;

  logic clk = 1'b0;
  logic resetn;

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  logic [0:0] out1, bin1;
  logic       wrap1;
  logic [3:0] out4, bin4;
  logic       wrap4;
  logic [7:0] out8, bin8;
  logic       wrap8;

  top_graycode #(.DATA_WIDTH(1)) dut1 (
    .clk(clk), .resetn(resetn), .out(out1), .bin_out(bin1), .wrap(wrap1));
  top_graycode #(.DATA_WIDTH(4)) dut4 (
    .clk(clk), .resetn(resetn), .out(out4), .bin_out(bin4), .wrap(wrap4));
  top_graycode #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .out(out8), .bin_out(bin8), .wrap(wrap8));

  int errors = 0;
  int checks = 0;

  // Reference model state: count and expected wrap per width.
  int  n1 = 0, n4 = 0, n8 = 0;
  bit  w1 = 0, w4 = 0, w8 = 0;
  bit  prev_ok = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Gray value of an integer count, straight from the definition.
  function automatic int to_gray(input int n);
    return n ^ (n >> 1);
  endfunction

  // Gray to binary: binary bit i is the parity of Gray bits w-1..i.
  function automatic int from_gray(input int g, input int w);
    int b = 0;
    for (int i = 0; i < w; i++) begin
      int par = 0;
      for (int j = i; j < w; j++) par ^= (g >> j) & 1;
      b |= par << i;
    end
    return b;
  endfunction

  // Drive reset level, take one rising edge, update the model, check all.
  task automatic tick(input bit rst);
    logic [0:0] p1;
    logic [3:0] p4;
    logic [7:0] p8;
    p1 = out1; p4 = out4; p8 = out8;
    resetn = rst;
    @(posedge clk);
    #1;
    if (rst) begin
      n1 = 0; n4 = 0; n8 = 0;
      w1 = 0; w4 = 0; w8 = 0;
    end else begin
      n1 = (n1 + 1) % 2;   w1 = (n1 == 0);
      n4 = (n4 + 1) % 16;  w4 = (n4 == 0);
      n8 = (n8 + 1) % 256; w8 = (n8 == 0);
    end
    check("out_w1",  32'(out1),  32'(to_gray(n1)));
    check("bin_w1",  32'(bin1),  32'(n1));
    check("wrap_w1", 32'(wrap1), 32'(w1));
    check("out_w4",  32'(out4),  32'(to_gray(n4)));
    check("bin_w4",  32'(bin4),  32'(n4));
    check("wrap_w4", 32'(wrap4), 32'(w4));
    check("out_w8",  32'(out8),  32'(to_gray(n8)));
    check("bin_w8",  32'(bin8),  32'(n8));
    check("wrap_w8", 32'(wrap8), 32'(w8));
    check("g2b_w1", 32'(from_gray(int'(out1), 1)), 32'(bin1));
    check("g2b_w4", 32'(from_gray(int'(out4), 4)), 32'(bin4));
    check("g2b_w8", 32'(from_gray(int'(out8), 8)), 32'(bin8));
    if (!rst && prev_ok) begin
      check("onebit_w1", 32'($countones(out1 ^ p1)), 32'd1);
      check("onebit_w4", 32'($countones(out4 ^ p4)), 32'd1);
      check("onebit_w8", 32'($countones(out8 ^ p8)), 32'd1);
    end
    prev_ok = 1;
  endtask

  logic [3:0] seq [20] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC, 4'hD,
                           4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0, 4'h1, 4'h3, 4'h2};
  logic [3:0] resume [3] = '{4'h1, 4'h3, 4'h2};

  initial begin
    int wrap_cnt;
    resetn = 1'b1;

    // Reset held for three edges.
    repeat (3) tick(1);
    check("rst_out", 32'(out4), 32'd0);
    check("rst_bin", 32'(bin4), 32'd0);
    check("rst_wrap", 32'(wrap4), 32'd0);

    // Twenty consecutive samples, first one is the post-reset zero.
    check("seq0", 32'(out4), 32'(seq[0]));
    for (int i = 1; i < 20; i++) begin
      tick(0);
      check($sformatf("seq%0d", i), 32'(out4), 32'(seq[i]));
    end

    // Two rollovers in 32 edges.
    tick(1);
    wrap_cnt = 0;
    for (int i = 1; i <= 32; i++) begin
      tick(0);
      if (wrap4) wrap_cnt++;
      if (i == 16) check("wrap16", 32'(wrap4), 32'd1);
    end
    check("wrap_count", 32'(wrap_cnt), 32'd2);

    // Reset in the middle of a run.
    tick(1);
    repeat (7) tick(0);
    check("mid_pre", 32'(out4), 32'h4);
    tick(1);
    check("mid_rst", 32'(out4), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(0);
      check($sformatf("mid_resume%0d", i), 32'(out4), 32'(resume[i]));
    end

    // Full cycle of the widest instance plus two edges.
    tick(1);
    repeat (258) tick(0);

    // Random reset pulses sprinkled over a long run.
    repeat (600) tick($urandom_range(0, 39) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
